// File: rtl/prod_pkg.sv
// Shared types for the 2-safety product scheduler: FSM state encoding and default widths.
package prod_pkg;

    localparam int OBS_W_DEF = 64;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_RUN,
        ST_WAIT_L,
        ST_WAIT_R,
        ST_DONE,
        ST_FAIL
    } sched_state_e;

endpackage

// File: rtl/prod_obs_cmp.sv
// Observation buffer for the copy that retired first, plus the equality check against the partner.
module prod_obs_cmp
    import prod_pkg::*;
#(
    parameter int OBS_W = OBS_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  sched_state_e     state,
    input  logic             load_en,
    input  logic             load_right,
    input  logic [OBS_W-1:0] obs_left,
    input  logic [OBS_W-1:0] obs_right,
    output logic             match
);

    logic [OBS_W-1:0] obs_buf;
    logic [OBS_W-1:0] lhs;
    logic [OBS_W-1:0] rhs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obs_buf <= '0;
        end else if (load_en) begin
            obs_buf <= load_right ? obs_right : obs_left;
        end
    end

    // The stalled side's observation lives in the buffer; the other side is live.
    always_comb begin
        lhs = obs_left;
        rhs = obs_right;
        case (state)
            ST_WAIT_L: lhs = obs_buf;
            ST_WAIT_R: rhs = obs_buf;
            default:   ;
        endcase
    end

    assign match = (lhs == rhs);

endmodule

// File: rtl/prod_stutter_sched.sv
// Lock-step scheduler for the Left/Right core pair: init window, stutter alignment of
// retirements, pairwise observation compare and sticky equivalence verdict.
module prod_stutter_sched
    import prod_pkg::*;
#(
    parameter int OBS_W       = OBS_W_DEF,
    parameter int INIT_CYCLES = 4,
    parameter int MAX_STUTTER = 16,
    parameter int BOUND       = 32,
    parameter int CNT_W       = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             retire_left_i,
    input  logic             retire_right_i,
    input  logic [OBS_W-1:0] obs_left_i,
    input  logic [OBS_W-1:0] obs_right_i,
    output logic             core_rst_no,
    output logic             en_left_o,
    output logic             en_right_o,
    output logic             equiv_o,
    output logic             mismatch_o,
    output logic             timeout_o,
    output logic             done_o,
    output logic [CNT_W-1:0] retire_cnt_o
);

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int STUT_W = $clog2(MAX_STUTTER + 1);

    sched_state_e      state;
    sched_state_e      next;
    logic [INIT_W-1:0] init_cnt;
    logic [STUT_W-1:0] stut_cnt;
    logic              ret_l;
    logic              ret_r;
    logic              obs_eq;
    logic              init_last;
    logic              stut_expired;
    logic              last_pair;
    logic              pair_ok;
    logic              pair_bad;
    logic              stut_timeout;
    logic              waiting;
    logic              partner_ret;

    // A retire only counts while that copy is actually clocked.
    assign ret_l        = retire_left_i & en_left_o;
    assign ret_r        = retire_right_i & en_right_o;
    assign init_last    = (init_cnt == INIT_W'(INIT_CYCLES - 1));
    assign stut_expired = (stut_cnt == STUT_W'(MAX_STUTTER - 1));
    assign last_pair    = (retire_cnt_o == CNT_W'(BOUND - 1));
    assign waiting      = (state == ST_WAIT_L) || (state == ST_WAIT_R);
    assign partner_ret  = ((state == ST_WAIT_L) && ret_r) || ((state == ST_WAIT_R) && ret_l);

    prod_obs_cmp #(.OBS_W(OBS_W)) u_cmp (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .state     (state),
        .load_en   ((state == ST_RUN) && (ret_l ^ ret_r)),
        .load_right(ret_r),
        .obs_left  (obs_left_i),
        .obs_right (obs_right_i),
        .match     (obs_eq)
    );

    always_comb begin
        next         = state;
        pair_ok      = 1'b0;
        pair_bad     = 1'b0;
        stut_timeout = 1'b0;
        case (state)
            ST_INIT: if (init_last) next = ST_RUN;
            ST_RUN: begin
                if (ret_l && ret_r) begin
                    pair_ok  = obs_eq;
                    pair_bad = !obs_eq;
                end else if (ret_l) begin
                    next = ST_WAIT_L;
                end else if (ret_r) begin
                    next = ST_WAIT_R;
                end
            end
            ST_WAIT_L, ST_WAIT_R: begin
                // A partner retire on the last allowed cycle still pairs up.
                if (partner_ret) begin
                    pair_ok  = obs_eq;
                    pair_bad = !obs_eq;
                end else if (stut_expired) begin
                    stut_timeout = 1'b1;
                end
            end
            default: ;
        endcase
        if (pair_ok) next = last_pair ? ST_DONE : ST_RUN;
        if (pair_bad || stut_timeout) next = ST_FAIL;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_INIT;
            init_cnt     <= '0;
            stut_cnt     <= '0;
            core_rst_no  <= 1'b0;
            en_left_o    <= 1'b0;
            en_right_o   <= 1'b0;
            equiv_o      <= 1'b1;
            mismatch_o   <= 1'b0;
            timeout_o    <= 1'b0;
            done_o       <= 1'b0;
            retire_cnt_o <= '0;
        end else begin
            state       <= next;
            core_rst_no <= (state != ST_INIT);
            en_left_o   <= (next == ST_RUN) || (next == ST_WAIT_R);
            en_right_o  <= (next == ST_RUN) || (next == ST_WAIT_L);
            equiv_o     <= (next != ST_FAIL);
            if (state == ST_INIT && !init_last) init_cnt <= init_cnt + 1'b1;
            if (waiting && !partner_ret) stut_cnt <= stut_cnt + 1'b1;
            else                          stut_cnt <= '0;
            if (pair_ok)               retire_cnt_o <= retire_cnt_o + 1'b1;
            if (pair_ok && last_pair)  done_o       <= 1'b1;
            if (pair_bad)              mismatch_o   <= 1'b1;
            if (stut_timeout)          timeout_o    <= 1'b1;
        end
    end

endmodule
